// File: rtl/usb_arb_pkg.sv
// Shared types and header field layout for the USB TX arbiter and related stream blocks.
package usb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // Header word layout: magic in the top byte, continuation flag, channel id.
    localparam int HDR_CONT_BIT = 8;
    localparam int HDR_ID_LSB   = 0;
    localparam int HDR_ID_W     = 8;
    localparam int HDR_MAGIC_W  = 8;

endpackage

// File: rtl/usb_rr_pick.sv
// Combinational rotating-priority picker: first asserted request above 'last', wrapping mod N.
module usb_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] idx;

    // Walk from the farthest candidate back to last+1 so the nearest one overwrites.
    always_comb begin
        gnt_id = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = N; i >= 1; i--) begin
            idx = IW'((int'(last) + i) % N);
            if (req[idx]) begin
                gnt_id = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one TX stream among N requesters,
// prefixing every granted burst with a header word (magic, continuation, id).
module usb_tx_arbiter
    import usb_arb_pkg::*;
#(
    parameter int         N         = 4,
    parameter int         DW        = 64,
    parameter int         MAX_BEATS = 256,
    parameter logic [7:0] HDR_MAGIC = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N-1:0]         s_valid,
    output logic [N-1:0]         s_ready,
    input  logic [N*DW-1:0]      s_data,
    input  logic [N-1:0]         s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DW-1:0]        m_data,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_BEATS + 1);

    arb_state_t    state_q;
    logic [IW-1:0] grant_q;
    logic [IW-1:0] last_q;
    logic [N-1:0]  cont_q;
    logic [CW-1:0] beat_q;
    logic          hdr_vld_q;
    logic [DW-1:0] hdr_data_q;

    logic [IW-1:0] pick_id;
    logic          pick_any;
    logic [DW-1:0] hdr_word_d;
    logic          in_data;
    logic          hs;

    usb_rr_pick #(.N(N)) u_pick (
        .req    (s_valid),
        .last   (last_q),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    // Header for the channel about to be granted; captured into a register on the IDLE->HDR step.
    always_comb begin
        hdr_word_d                              = '0;
        hdr_word_d[DW-1 -: HDR_MAGIC_W]         = HDR_MAGIC;
        hdr_word_d[HDR_CONT_BIT]                = cont_q[pick_id];
        hdr_word_d[HDR_ID_LSB +: HDR_ID_W]      = HDR_ID_W'(pick_id);
    end

    // Output muxing: registered header in HDR, straight pass-through of the granted channel in DATA.
    always_comb begin
        in_data  = (state_q == DATA);
        m_valid  = in_data ? s_valid[grant_q] : hdr_vld_q;
        m_data   = in_data ? s_data[grant_q*DW +: DW] : hdr_data_q;
        s_ready  = '0;
        if (in_data) s_ready[grant_q] = m_ready;
        hs       = m_valid & m_ready;
        busy     = (state_q != IDLE);
        grant_id = grant_q;
    end

    // Arbitration FSM, burst beat counter and per-channel continuation flags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= IW'(N - 1);
            cont_q     <= '0;
            beat_q     <= '0;
            hdr_vld_q  <= 1'b0;
            hdr_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q    <= pick_id;
                        hdr_vld_q  <= 1'b1;
                        hdr_data_q <= hdr_word_d;
                        state_q    <= HDR;
                    end
                end
                HDR: begin
                    if (m_ready) begin
                        hdr_vld_q  <= 1'b0;
                        hdr_data_q <= '0;
                        beat_q     <= '0;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    if (hs) begin
                        // A packet end at the beat limit closes the packet, so last is tested first.
                        if (s_last[grant_q]) begin
                            cont_q[grant_q] <= 1'b0;
                            last_q          <= grant_q;
                            state_q         <= IDLE;
                        end else if (beat_q == CW'(MAX_BEATS - 1)) begin
                            cont_q[grant_q] <= 1'b1;
                            last_q          <= grant_q;
                            state_q         <= IDLE;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/usb_tx_arbiter.md
# usb_tx_arbiter

Packet-level round-robin arbiter that shares the single `ftdi_245fifo` TX stream between N independent requester streams. Before each granted burst it inserts one header word carrying the channel id and a continuation flag, so the host can demultiplex. It sits in the `tx_clk` domain between the application streams and `ftdi_245fifo.tx_valid/tx_ready/tx_data`.

## Interface
- `N`, 4: number of requester channels; 2..16.
- `DW`, 64: stream data width; must equal the `ftdi_245fifo` TX width (`8<<TX_DEXP`); must be ≥32.
- `MAX_BEATS`, 256: maximum data beats per grant before a forced split; ≥1.
- `HDR_MAGIC`, 8'hA5: value placed in the header's top byte.

- `clk`  in  1  single clock; same clock as `ftdi_245fifo.tx_clk`.
- `rstn`  in  1  reset; synchronous, active-low.
- `s_valid`  in  N  per-channel data valid.
- `s_ready`  out  N  per-channel ready.
- `s_data`  in  N*DW  channel i occupies `[i*DW +: DW]`.
- `s_last`  in  N  last beat of the channel's packet.
- `m_valid`  out  1  to `ftdi_245fifo.tx_valid`.
- `m_ready`  in  1  from `ftdi_245fifo.tx_ready`.
- `m_data`  out  DW  to `ftdi_245fifo.tx_data`.
- `grant_id`  out  $clog2(N)  currently or last granted channel.
- `busy`  out  1  high in HDR or DATA.

## Operation
- States: IDLE, HDR, DATA.
- IDLE: `m_valid=0`, `s_ready=0`. If any `s_valid`, select the first asserted channel searching upward from `last_grant+1` (mod N), register it in `grant_id`, go to HDR. Otherwise stay in IDLE.
- HDR: `m_valid=1`. `m_data` is formed as follows: bits `[DW-1 -: 8]`=`HDR_MAGIC`, bit 8=`cont[g]`, bits `[7:0]`=g, all other bits 0. All `s_ready=0`. On `m_ready`, go to DATA and clear `beat_cnt`.
- DATA: pass-through of channel g only.
  - `m_valid=s_valid[g]`, `m_data=s_data[g]`, `s_ready[g]=m_ready`; other `s_ready=0`.
  - On a handshake with `s_last[g]`: `cont[g]<=0`, `last_grant<=g`, go to IDLE.
  - On a handshake with `beat_cnt==MAX_BEATS-1` and no last: `cont[g]<=1`, `last_grant<=g`, go to IDLE. The forced split lets other channels run.
  - Any other handshake: `beat_cnt++`.
- `beat_cnt` is $clog2(MAX_BEATS+1) bits wide and never wraps.
- If `s_last` coincides with the `MAX_BEATS` limit, `s_last` wins: `cont` is cleared.
- A channel dropping `s_valid` in DATA stalls the output. The grant is held; there is no timeout.
- `m_valid` is never withdrawn once asserted without a handshake (AXI-stream rule). In DATA this depends on requesters obeying the same rule.

## Timing
- Reset values: state=IDLE, `m_valid=0`, `s_ready=0`, `m_data=0`, `grant_id=0`, `busy=0`, `last_grant=N-1` (so channel 0 wins first), `cont=0`.
- Reset asserted mid-packet aborts the burst immediately. Host-side framing recovery uses `HDR_MAGIC`.
- Latency from first `s_valid` in IDLE: HDR appears on `m_valid` 1 cycle later.
- Header is accepted in 1 cycle if `m_ready=1`. Data then flows at 1 beat/cycle with a combinational path from `m_ready` to `s_ready`.
- Packet overhead: 1 idle cycle + 1 header beat per grant.
- `m_data` and `m_valid` are registered in HDR and combinational in DATA.

## Structure
- Package `usb_arb_pkg`:
  - state enum `arb_state_t` {IDLE, HDR, DATA};
  - constants `HDR_CONT_BIT=8`, `HDR_ID_LSB=0`, `HDR_ID_W=8`, `HDR_MAGIC_W=8`.
- Sub-module `usb_rr_pick`: purely combinational rotating-priority picker. Inputs: `req[N]`, `last`. Outputs: `gnt_id`, `any`. It is reused by a future RX demux.
- Top-level FSM, counter and muxing live in `usb_tx_arbiter`.

## Test plan
- **Single channel**: N=4, DW=64, ch1 sends 3 beats 0x11,0x22,0x33 (last on 0x33), `m_ready=1`. Expect `m_data`=0xA500_0000_0000_0001, then 0x11, 0x22, 0x33; `grant_id`=1; `busy` falls the cycle after 0x33.
- **Round robin**: ch0 and ch2 both continuously valid with 2-beat packets. Expect header ids in the order 0, 2, 0, 2, with each packet complete between headers.
- **Forced split**: MAX_BEATS=4, ch3 sends a 6-beat packet, no other requesters. Expect hdr(id3, cont=0), 4 beats, hdr(id3, cont=1), 2 beats; `cont[3]` is 0 afterwards.
- **Last coinciding with limit**: MAX_BEATS=4, 4-beat packet with last on beat 4. Expect no continuation header and `cont=0`.
- **Backpressure**: randomly toggle `m_ready` at 50% during the HDR and DATA states. Expect `m_valid`/`m_data` stable while `m_ready=0`, no lost or duplicated beats, and the scoreboard matching per-channel order.
- **Reset mid-packet**: deassert `rstn` for 1 cycle during DATA. Next cycle expect all outputs at their reset values; the following grant goes to ch0 if it is requesting.
